// File: rtl/gpio_pin_ctrl_if.sv
// Register bus between a host and gpio_pin_ctrl: write/read strobes, word address,
// write data, and the registered read data with its one-cycle valid pulse.
interface gpio_pin_ctrl_if;
    logic        wen;
    logic        ren;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (
        output wen,
        output ren,
        output addr,
        output wdata,
        input  rdata,
        input  rvalid
    );

    modport slave (
        input  wen,
        input  ren,
        input  addr,
        input  wdata,
        output rdata,
        output rvalid
    );
endinterface

// File: rtl/gpio_pin_ctrl.sv
// GPIO pin controller: synchronised pad inputs, output/direction registers, and per-pin
// level/edge interrupt detection with W1C status and a registered interrupt line.
module gpio_pin_ctrl #(
    parameter int unsigned NUM_PINS    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                CLK,
    input  logic                RST,
    gpio_pin_ctrl_if.slave      bus,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic [NUM_PINS-1:0] gpio_out,
    output logic [NUM_PINS-1:0] gpio_oe,
    output logic                interrupt
);

    if (NUM_PINS < 1 || NUM_PINS > 32) begin : g_bad_pins
        $error("gpio_pin_ctrl: NUM_PINS must be 1..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("gpio_pin_ctrl: SYNC_STAGES must be 2..3");
    end

    typedef enum logic [2:0] {
        AddrDataIn    = 3'd0,
        AddrDataOut   = 3'd1,
        AddrDir       = 3'd2,
        AddrIntEn     = 3'd3,
        AddrIntType   = 3'd4,
        AddrIntPol    = 3'd5,
        AddrIntStatus = 3'd6,
        AddrIntBoth   = 3'd7
    } reg_addr_e;

    reg_addr_e reg_addr;
    assign reg_addr = reg_addr_e'(bus.addr);

    logic [NUM_PINS-1:0] wdata_pins;
    assign wdata_pins = bus.wdata[NUM_PINS-1:0];

    // Upper write-data bits are intentionally ignored when NUM_PINS < 32.
    logic unused_wdata;
    assign unused_wdata = ^bus.wdata;

    // ------------------------------------------------------------------
    // Input synchroniser and previous-sample register
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q;
    logic [NUM_PINS-1:0]                  prev_q;
    logic [NUM_PINS-1:0]                  data_in;

    assign data_in = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
            prev_q <= data_in;
        end
    end

    // ------------------------------------------------------------------
    // Configuration and status registers
    // ------------------------------------------------------------------
    logic [NUM_PINS-1:0] data_out_q, data_out_d;
    logic [NUM_PINS-1:0] dir_q,      dir_d;
    logic [NUM_PINS-1:0] int_en_q,   int_en_d;
    logic [NUM_PINS-1:0] int_type_q, int_type_d;
    logic [NUM_PINS-1:0] int_pol_q,  int_pol_d;
    logic [NUM_PINS-1:0] int_both_q, int_both_d;
    logic [NUM_PINS-1:0] status_q,   status_d;
    logic [NUM_PINS-1:0] status_clr;
    logic [NUM_PINS-1:0] pin_event;

    // Event detection always uses the registered mode bits, so a mode write takes
    // effect from the cycle after it lands and never touches pending status.
    logic [NUM_PINS-1:0] rising, falling, edge_event, level_event;

    always_comb begin
        rising      = data_in & ~prev_q;
        falling     = ~data_in & prev_q;
        edge_event  = (int_both_q & (data_in ^ prev_q)) |
                      (~int_both_q & ((int_pol_q & rising) | (~int_pol_q & falling)));
        level_event = ~(data_in ^ int_pol_q);
        pin_event   = (int_type_q & edge_event) | (~int_type_q & level_event);
    end

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        int_en_d   = int_en_q;
        int_type_d = int_type_q;
        int_pol_d  = int_pol_q;
        int_both_d = int_both_q;
        status_clr = '0;
        if (bus.wen) begin
            unique case (reg_addr)
                AddrDataIn:    ;
                AddrDataOut:   data_out_d = wdata_pins;
                AddrDir:       dir_d      = wdata_pins;
                AddrIntEn:     int_en_d   = wdata_pins;
                AddrIntType:   int_type_d = wdata_pins;
                AddrIntPol:    int_pol_d  = wdata_pins;
                AddrIntStatus: status_clr = wdata_pins;
                AddrIntBoth:   int_both_d = wdata_pins;
                default:       ;
            endcase
        end
        // Set is OR-ed after the clear so a fresh event beats a same-cycle W1C.
        status_d = (status_q & ~status_clr) | pin_event;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            data_out_q <= '0;
            dir_q      <= '0;
            int_en_q   <= '0;
            int_type_q <= '0;
            int_pol_q  <= '0;
            int_both_q <= '0;
            status_q   <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            int_en_q   <= int_en_d;
            int_type_q <= int_type_d;
            int_pol_q  <= int_pol_d;
            int_both_q <= int_both_d;
            status_q   <= status_d;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [NUM_PINS-1:0] rd_sel;
    logic [31:0]         rd_word;
    logic [31:0]         rdata_q;
    logic                rvalid_q;

    always_comb begin
        rd_sel = '0;
        unique case (reg_addr)
            AddrDataIn:    rd_sel = data_in;
            AddrDataOut:   rd_sel = data_out_q;
            AddrDir:       rd_sel = dir_q;
            AddrIntEn:     rd_sel = int_en_q;
            AddrIntType:   rd_sel = int_type_q;
            AddrIntPol:    rd_sel = int_pol_q;
            AddrIntStatus: rd_sel = status_q;
            AddrIntBoth:   rd_sel = int_both_q;
            default:       rd_sel = '0;
        endcase
        rd_word                = '0;
        rd_word[NUM_PINS-1:0]  = rd_sel;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= bus.ren;
            if (bus.ren) begin
                rdata_q <= rd_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Interrupt and pad outputs
    // ------------------------------------------------------------------
    logic interrupt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            interrupt_q <= 1'b0;
        end else begin
            interrupt_q <= |(status_q & int_en_q);
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign gpio_out   = data_out_q;
    assign gpio_oe    = dir_q;
    assign interrupt  = interrupt_q;

endmodule

// File: tb/tb_gpio_pin_ctrl.sv
// Randomized bench for gpio_pin_ctrl against a cycle-level reference model of the
// register map, with directed scenarios for the key interrupt and reset behaviours.
module tb_gpio_pin_ctrl;

    localparam int unsigned NP = 8;
    localparam int unsigned SS = 2;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    gpio_pin_ctrl_if bus   ();
    gpio_pin_ctrl_if bus32 ();
    gpio_pin_ctrl_if bus1  ();

    logic [NP-1:0] gpio_in = '0;
    logic [NP-1:0] gpio_out, gpio_oe;
    logic          interrupt;

    logic [31:0] out32, oe32;
    logic        irq32;
    logic [0:0]  out1, oe1;
    logic        irq1;

    gpio_pin_ctrl #(.NUM_PINS(NP), .SYNC_STAGES(SS)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus.slave),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oe   (gpio_oe),
        .interrupt (interrupt)
    );

    gpio_pin_ctrl #(.NUM_PINS(32), .SYNC_STAGES(3)) dut32 (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus32.slave),
        .gpio_in   (32'h0),
        .gpio_out  (out32),
        .gpio_oe   (oe32),
        .interrupt (irq32)
    );

    gpio_pin_ctrl #(.NUM_PINS(1), .SYNC_STAGES(2)) dut1 (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus1.slave),
        .gpio_in   (1'b0),
        .gpio_out  (out1),
        .gpio_oe   (oe1),
        .interrupt (irq1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: m_reg indexed by register address (index 0 unused, 6 = status).
    logic [NP-1:0] m_reg [8];
    logic [NP-1:0] m_pipe [SS];
    logic [NP-1:0] m_prev;
    logic [31:0]   m_rdata;
    logic          m_rvalid;
    logic          m_irq;
    bit            m_live = 1'b0;
    logic [NP-1:0] gin_cur = '0;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        for (int i = 0; i < int'(SS); i++) m_pipe[i] = '0;
        m_prev   = '0;
        m_rdata  = '0;
        m_rvalid = 1'b0;
        m_irq    = 1'b0;
    endtask

    // One clock cycle: compare outputs of the previous edge, drive inputs, advance model.
    task automatic step(input logic rst, input logic wen, input logic ren,
                        input logic [2:0] a, input logic [31:0] wd, input logic [NP-1:0] gin);
        logic [NP-1:0] din, ev, sel;
        bit            now, was;
        @(negedge CLK);
        if (m_live) begin
            check_eq("rdata",     bus.rdata,              m_rdata);
            check_eq("rvalid",    32'(bus.rvalid),        32'(m_rvalid));
            check_eq("gpio_out",  32'(gpio_out),          32'(m_reg[1]));
            check_eq("gpio_oe",   32'(gpio_oe),           32'(m_reg[2]));
            check_eq("interrupt", 32'(interrupt),         32'(m_irq));
        end
        RST       = rst;
        bus.wen   = wen;
        bus.ren   = ren;
        bus.addr  = a;
        bus.wdata = wd;
        gpio_in   = gin;

        if (rst) begin
            model_reset();
            m_live = 1'b1;
        end else begin
            din = m_pipe[SS-1];
            for (int i = 0; i < int'(NP); i++) begin
                now = din[i];
                was = m_prev[i];
                if (!m_reg[4][i])      ev[i] = (now == m_reg[5][i]);
                else if (m_reg[7][i])  ev[i] = (now != was);
                else if (m_reg[5][i])  ev[i] = (!was && now);
                else                   ev[i] = (was && !now);
            end
            m_irq    = |(m_reg[6] & m_reg[3]);
            m_rvalid = ren;
            if (ren) begin
                sel     = (a == 3'd0) ? din : m_reg[a];
                m_rdata = 32'(sel);
            end
            if (wen) begin
                if (a == 3'd6)      m_reg[6] = m_reg[6] & ~wd[NP-1:0];
                else if (a != 3'd0) m_reg[a] = wd[NP-1:0];
            end
            m_reg[6] = m_reg[6] | ev;
            m_prev   = din;
            for (int i = int'(SS) - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = gin;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, gin_cur);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b0, a, d, gin_cur);
    endtask

    task automatic rd(input logic [2:0] a);
        step(1'b0, 1'b0, 1'b1, a, 32'h0, gin_cur);
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) idle();
    endtask

    initial begin
        bus.wen = 0; bus.ren = 0; bus.addr = '0; bus.wdata = '0;
        bus32.wen = 0; bus32.ren = 0; bus32.addr = '0; bus32.wdata = '0;
        bus1.wen = 0; bus1.ren = 0; bus1.addr = '0; bus1.wdata = '0;

        step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, '0);
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, '0);
        idle();
        check_eq("reset_oe",  32'(gpio_oe),  32'h0);
        check_eq("reset_out", 32'(gpio_out), 32'h0);

        // Output/direction and registered read latency.
        wr(3'd2, 32'h0000_000F);
        wr(3'd1, 32'hFFFF_FFA5);
        rd(3'd1);
        idle();
        check_eq("dir_oe",     32'(gpio_oe),      32'h0F);
        check_eq("out_data",   32'(gpio_out),     32'hA5);
        check_eq("rd_dataout", bus.rdata,         32'h0000_00A5);
        check_eq("rd_valid",   32'(bus.rvalid),   32'h1);

        // Rising edge on pin 3.
        wr(3'd4, 32'hFF);
        wr(3'd5, 32'h08);
        wr(3'd6, 32'hFF);
        wr(3'd3, 32'h08);
        idle();
        rd(3'd6);
        idle();
        check_eq("status_clean", bus.rdata, 32'h0);
        gin_cur[3] = 1'b1;
        idles(4);
        rd(3'd6);
        idle();
        check_eq("rise_status", bus.rdata,       32'h08);
        check_eq("rise_irq",    32'(interrupt),  32'h1);
        wr(3'd6, 32'h08);
        idles(2);
        rd(3'd6);
        idle();
        check_eq("w1c_status", bus.rdata,      32'h0);
        check_eq("w1c_irq",    32'(interrupt), 32'h0);

        // Both-edge mode on pin 5.
        wr(3'd7, 32'h20);
        gin_cur[5] = 1'b1;
        idles(4);
        rd(3'd6);
        idle();
        check_eq("both_rise", bus.rdata, 32'h20);
        gin_cur[5] = 1'b0;
        wr(3'd6, 32'h20);
        idles(4);
        rd(3'd6);
        idle();
        check_eq("both_fall", bus.rdata, 32'h20);

        // Level-low on pin 0: clear loses to the persisting level.
        wr(3'd4, 32'hFE);
        wr(3'd3, 32'h01);
        idles(2);
        wr(3'd6, 32'h01);
        idle();
        rd(3'd6);
        idle();
        check_eq("level_reset", bus.rdata & 32'h1, 32'h1);
        check_eq("level_irq",   32'(interrupt),    32'h1);

        // Wide and narrow builds truncate write data to the pin count.
        bus32.wen = 1; bus32.addr = 3'd1; bus32.wdata = 32'hFFFF_FFFF;
        bus1.wen  = 1; bus1.addr  = 3'd1; bus1.wdata  = 32'hFFFF_FFFF;
        idle();
        bus32.wen = 0; bus32.ren = 1;
        bus1.wen  = 0; bus1.ren  = 1;
        idle();
        check_eq("np32_rdata", bus32.rdata, 32'hFFFF_FFFF);
        check_eq("np1_rdata",  bus1.rdata,  32'h0000_0001);
        check_eq("np1_rvalid", 32'(bus1.rvalid), 32'h1);
        bus32.ren = 0;
        bus1.ren  = 0;

        // Reset with status pending and a read in flight.
        step(1'b1, 1'b0, 1'b1, 3'd6, 32'h0, gin_cur);
        gin_cur = '0;
        idle();
        check_eq("rst_rvalid", 32'(bus.rvalid), 32'h0);
        check_eq("rst_rdata",  bus.rdata,       32'h0);
        check_eq("rst_irq",    32'(interrupt),  32'h0);
        check_eq("rst_out",    32'(gpio_out),   32'h0);
        idles(4);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic r_rst, r_wen, r_ren;
            r_rst = ($urandom_range(0, 199) == 0);
            r_wen = ($urandom_range(0, 2) == 0);
            r_ren = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 3) == 0) gin_cur[$urandom_range(0, NP - 1)] ^= 1'b1;
            step(r_rst, r_wen, r_ren, 3'($urandom_range(0, 7)), $urandom, gin_cur);
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
